alu_ctrl_decoder: RTL and testbench

- Control-side counterpart of the datapath ALU: accepts RV32I instruction words and produces the alu_op code, operand indices, immediate and write-enable that drive the ALU and register file.
- Registered single-stage decoder with a valid/ready handshake on both sides and a 1-entry skid buffer, so in_ready is a pure register output.
- Sits between instruction fetch and the register-file/ALU stage.

---
 rtl/alu_ctrl_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_ctrl_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decoder
//
// Registered RV32I ALU-instruction decoder. Takes instruction words from fetch
// over a valid/ready handshake, decodes them combinationally and registers the
// result into a single output stage backed by a 1-entry skid buffer. The skid
// buffer lets in_ready come straight from a flop instead of depending on
// out_ready.
//
// Optional feature macro: ALU_DEC_LUI_EN
//   defined   : LUI (opcode 0110111) decodes as add with imm = {instr[31:12], 12'h000}
//   undefined : LUI is reported as illegal
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   instr is valid
//   in_ready   out  decoder can accept instr this cycle (registered)
//   instr      in   32-bit RV32I instruction word
//   out_valid  out  decoded fields are valid
//   out_ready  in   consumer accepts decoded fields
//   alu_op     out  4-bit ALU operation code
//   rs1_addr   out  source register 1 index
//   rs2_addr   out  source register 2 index
//   rd_addr    out  destination register index
//   imm        out  XLEN-bit immediate operand
//   use_imm    out  1: operand B = imm, 0: operand B = rs2 data
//   reg_write  out  write rd with the ALU result
//   illegal    out  instruction is not a supported ALU instruction
// -----------------------------------------------------------------------------
module alu_ctrl_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic            use_imm,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_write;
        logic            illegal;
    } dec_t;

    // Pure decode of one instruction word. Illegal words zero every field and
    // set only the illegal flag, so downstream never sees partial decode.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t            d;
        logic            legal;
        logic [3:0]      op;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic [XLEN-1:0] im;
        logic            ui;
        logic [6:0]      f7;
        logic [2:0]      f3;
        f7    = w[31:25];
        f3    = w[14:12];
        legal = 1'b0;
        op    = OP_ADD;
        r1    = w[19:15];
        r2    = 5'd0;
        im    = {XLEN{1'b0}};
        ui    = 1'b0;
        case (w[6:0])
            OPC_R: begin
                r2 = w[24:20];
                case (f7)
                    7'b0000000: begin
                        legal = 1'b1;
                        case (f3)
                            3'b000:  op = OP_ADD;
                            3'b001:  op = OP_SLL;
                            3'b010:  op = OP_SLT;
                            3'b011:  op = OP_SLTU;
                            3'b100:  op = OP_XOR;
                            3'b101:  op = OP_SRL;
                            3'b110:  op = OP_OR;
                            3'b111:  op = OP_AND;
                            default: legal = 1'b0;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000: begin
                                legal = 1'b1;
                                op    = OP_SUB;
                            end
                            3'b101: begin
                                legal = 1'b1;
                                op    = OP_SRA;
                            end
                            default: legal = 1'b0;
                        endcase
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_I: begin
                ui = 1'b1;
                // Non-shift forms use the full signed 12-bit immediate.
                im = {{(XLEN-12){w[31]}}, w[31:20]};
                case (f3)
                    3'b000: begin legal = 1'b1; op = OP_ADD;  end
                    3'b010: begin legal = 1'b1; op = OP_SLT;  end
                    3'b011: begin legal = 1'b1; op = OP_SLTU; end
                    3'b100: begin legal = 1'b1; op = OP_XOR;  end
                    3'b110: begin legal = 1'b1; op = OP_OR;   end
                    3'b111: begin legal = 1'b1; op = OP_AND;  end
                    3'b001: begin
                        // Shifts carry only a 5-bit shamt; upper bits select the kind.
                        im    = {{(XLEN-5){1'b0}}, w[24:20]};
                        legal = (f7 == 7'b0000000);
                        op    = OP_SLL;
                    end
                    3'b101: begin
                        im = {{(XLEN-5){1'b0}}, w[24:20]};
                        if (f7 == 7'b0000000) begin
                            legal = 1'b1;
                            op    = OP_SRL;
                        end else if (f7 == 7'b0100000) begin
                            legal = 1'b1;
                            op    = OP_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
`ifdef ALU_DEC_LUI_EN
            OPC_LUI: begin
                legal = 1'b1;
                op    = OP_ADD;
                r1    = 5'd0;
                ui    = 1'b1;
                im    = {w[31:12], 12'h000};
            end
`else
            OPC_LUI: legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
        if (legal) begin
            d.alu_op    = op;
            d.rs1       = r1;
            d.rs2       = r2;
            d.rd        = w[11:7];
            d.imm       = im;
            d.use_imm   = ui;
            d.reg_write = (w[11:7] != 5'd0);
            d.illegal   = 1'b0;
        end else begin
            d         = '0;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    dec_t dec_s;
    dec_t out_r;
    dec_t skid_r;
    logic out_valid_r;
    logic skid_valid_r;
    logic in_ready_r;
    logic accept_s;
    logic out_free_s;

    // Combinational decode and handshake qualifiers.
    always_comb begin
        dec_s      = decode(instr);
        accept_s   = in_valid && in_ready_r;
        out_free_s = !out_valid_r || out_ready;
    end

    // Output stage, skid buffer and registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (out_free_s) begin
            // Skid holds the older word, so it always drains first. in_ready
            // is low whenever the skid is full, so no accept collides here.
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
            in_ready_r <= 1'b1;
        end else begin
            // Output stalled: an accepted word parks in the (empty) skid.
            if (accept_s) begin
                skid_r       <= dec_s;
                skid_valid_r <= 1'b1;
                in_ready_r   <= 1'b0;
            end else begin
                in_ready_r <= !skid_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign alu_op    = out_r.alu_op;
    assign rs1_addr  = out_r.rs1;
    assign rs2_addr  = out_r.rs2;
    assign rd_addr   = out_r.rd;
    assign imm       = out_r.imm;
    assign use_imm   = out_r.use_imm;
    assign reg_write = out_r.reg_write;
    assign illegal   = out_r.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for alu_ctrl_decoder. Observed outputs are packed
// as {out_valid, alu_op, rs1, rs2, rd, imm, use_imm, reg_write, illegal} and
// compared against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;

    int vectors    = 0;
    int miscompares = 0;

    alu_ctrl_decoder #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .imm(imm), .use_imm(use_imm), .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [54:0] obs;
    assign obs = {out_valid, alu_op, rs1_addr, rs2_addr, rd_addr, imm, use_imm, reg_write, illegal};

    // Packs an expected output tuple in the same layout as obs.
    function automatic logic [54:0] ex(input logic v, input logic [3:0] op, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] im,
                                       input logic ui, input logic rw, input logic il);
        return {v, op, r1, r2, rd, im, ui, rw, il};
    endfunction

    localparam logic [54:0] E_ILL = {1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1};

    // Presents one word with out_ready=1; returns at the negedge after acceptance.
    task automatic drive_single(input logic [31:0] w);
        @(negedge clk);
        in_valid  = 1'b1;
        instr     = w;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (obs !== 55'd0 || in_ready !== 1'b1) begin
            $display("FAIL reset: obs=%h in_ready=%b, want obs=0 in_ready=1", obs, in_ready);
            miscompares++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] words [0:6];
        logic [54:0] exp_v [0:6];
        words[0] = 32'h002081B3; exp_v[0] = ex(1'b1, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b0);
        words[1] = 32'h407302B3; exp_v[1] = ex(1'b1, 4'b0010, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        words[2] = 32'hFFF00093; exp_v[2] = ex(1'b1, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        words[3] = 32'h40325213; exp_v[3] = ex(1'b1, 4'b1000, 5'd4, 5'd0, 5'd4, 32'h00000003, 1'b1, 1'b1, 1'b0);
        words[4] = 32'hFE325213; exp_v[4] = E_ILL;
        words[5] = 32'h00000000; exp_v[5] = E_ILL;
        words[6] = 32'h00208033; exp_v[6] = ex(1'b1, 4'b0000, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive_single(words[i]);
            vectors++;
            if (obs !== exp_v[i]) begin
                $display("FAIL basic[%0d] instr=%h: got %h want %h", i, words[i], obs, exp_v[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_rtype();
        logic [3:0] ops [0:7];
        ops[0] = 4'b0000; ops[1] = 4'b0110; ops[2] = 4'b1001; ops[3] = 4'b1010;
        ops[4] = 4'b0011; ops[5] = 4'b0111; ops[6] = 4'b0100; ops[7] = 4'b0101;
        for (int f = 0; f < 8; f++) begin
            drive_single({7'b0000000, 5'd11, 5'd10, 3'(f), 5'd9, 7'b0110011});
            vectors++;
            if (obs !== ex(1'b1, ops[f], 5'd10, 5'd11, 5'd9, 32'd0, 1'b0, 1'b1, 1'b0)) begin
                $display("FAIL rtype f3=%0d: got %h", f, obs);
                miscompares++;
            end
        end
        // funct7=0100000 with funct3=001, and funct7=0000001 (M extension): illegal.
        drive_single({7'b0100000, 5'd11, 5'd10, 3'b001, 5'd9, 7'b0110011});
        vectors++;
        if (obs !== E_ILL) begin
            $display("FAIL rtype_bad_f3: got %h want %h", obs, E_ILL);
            miscompares++;
        end
        drive_single({7'b0000001, 5'd11, 5'd10, 3'b000, 5'd9, 7'b0110011});
        vectors++;
        if (obs !== E_ILL) begin
            $display("FAIL rtype_mul: got %h want %h", obs, E_ILL);
            miscompares++;
        end
    endtask

    task automatic test_itype();
        logic [3:0]  ops [0:7];
        logic [11:0] fld;
        logic [31:0] eim;
        ops[0] = 4'b0000; ops[1] = 4'b0110; ops[2] = 4'b1001; ops[3] = 4'b1010;
        ops[4] = 4'b0011; ops[5] = 4'b0111; ops[6] = 4'b0100; ops[7] = 4'b0101;
        for (int f = 0; f < 8; f++) begin
            if (f == 1 || f == 5) begin
                fld = 12'h01F; eim = 32'h0000001F;
            end else begin
                fld = 12'h800; eim = 32'hFFFFF800;
            end
            drive_single({fld, 5'd17, 3'(f), 5'd20, 7'b0010011});
            vectors++;
            if (obs !== ex(1'b1, ops[f], 5'd17, 5'd0, 5'd20, eim, 1'b1, 1'b1, 1'b0)) begin
                $display("FAIL itype f3=%0d: got %h", f, obs);
                miscompares++;
            end
        end
        // slli with upper bits 0100000 is not a legal encoding.
        drive_single({7'b0100000, 5'd3, 5'd17, 3'b001, 5'd20, 7'b0010011});
        vectors++;
        if (obs !== E_ILL) begin
            $display("FAIL itype_bad_slli: got %h want %h", obs, E_ILL);
            miscompares++;
        end
    endtask

    task automatic test_lui();
        logic [54:0] e;
`ifdef ALU_DEC_LUI_EN
        e = ex(1'b1, 4'b0000, 5'd0, 5'd0, 5'd2, 32'h12345000, 1'b1, 1'b1, 1'b0);
`else
        e = E_ILL;
`endif
        drive_single(32'h12345137);
        vectors++;
        if (obs !== e) begin
            $display("FAIL lui: got %h want %h", obs, e);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        localparam logic [54:0] EA = {1'b1, 4'b0000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 1'b0};
        localparam logic [54:0] EB = {1'b1, 4'b0010, 5'd6, 5'd7, 5'd5, 32'd0, 1'b0, 1'b1, 1'b0};
        localparam logic [54:0] EC = {1'b1, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
        @(posedge clk);                     // A -> output stage
        @(negedge clk);
        instr = 32'h407302B3;
        @(posedge clk);                     // B -> skid
        @(negedge clk);
        instr = 32'hFFF00093;
        vectors++;
        if (obs !== EA || in_ready !== 1'b0) begin
            $display("FAIL bp_hold1: got %h in_ready=%b want %h in_ready=0", obs, in_ready, EA);
            miscompares++;
        end
        @(posedge clk);                     // C not accepted, A held
        @(negedge clk);
        vectors++;
        if (obs !== EA || in_ready !== 1'b0) begin
            $display("FAIL bp_hold2: got %h in_ready=%b want %h in_ready=0", obs, in_ready, EA);
            miscompares++;
        end
        out_ready = 1'b1;
        @(posedge clk);                     // A leaves, B from skid
        @(negedge clk);
        vectors++;
        if (obs !== EB || in_ready !== 1'b1) begin
            $display("FAIL bp_second: got %h in_ready=%b want %h in_ready=1", obs, in_ready, EB);
            miscompares++;
        end
        @(posedge clk);                     // B leaves, C accepted
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (obs !== EC) begin
            $display("FAIL bp_third: got %h want %h", obs, EC);
            miscompares++;
        end
        @(posedge clk);                     // C leaves, nothing follows
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
            miscompares++;
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
        @(posedge clk);
        @(negedge clk);
        instr = 32'h407302B3;
        @(posedge clk);                     // both stages full
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (obs !== 55'd0 || in_ready !== 1'b1) begin
            $display("FAIL reset_mid: obs=%h in_ready=%b want 0/1", obs, in_ready);
            miscompares++;
        end
        // A fresh word must pass through with nothing stale behind it.
        drive_single(32'hFFF00093);
        vectors++;
        if (obs !== {1'b1, 4'b0000, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL reset_mid_after: got %h", obs);
            miscompares++;
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_mid_stale: out_valid=%b want 0", out_valid);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rtype();
        test_itype();
        test_lui();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
